tmr_adder_ctrl: RTL and testbench

TMR_ADDER_CTRL -- requirements
Module: tmr_adder_ctrl

---
 rtl/tmr_adder_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_tmr_adder_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_adder_ctrl.sv
// tmr_adder_ctrl
// Collects N sign-magnitude operands onto a registered bus for an external
// TMR adder tree. It then samples the tree result and its voter-mismatch flag
// and holds the result until the consumer takes it.
// Build option: define TMR_ADDER_CTRL_RETRY_EN to re-evaluate the tree up to
// MAX_RETRY times after a voter mismatch. When it is not defined, the first
// mismatch is reported as an unrecoverable error.
module tmr_adder_ctrl #(
    parameter int N         = 8,
    parameter int WIDTH     = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   operand,
    input  logic [WIDTH-1:0]     tree_sum,
    input  logic                 tree_invalid,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;

    // One-cycle strobes decoded by the FSM and consumed by the datapath.
    logic load_fire;
    logic eval_pass;
    logic eval_fail;
    logic release_fire;

`ifdef TMR_ADDER_CTRL_RETRY_EN
    localparam int RETRY_W = 3;

    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_fire;
    logic               retry_left;

    assign retry_left = (retry_cnt < RETRY_W'(MAX_RETRY));
`endif

    // Reject parameter sets the counters cannot represent.
    generate
        if (N < 2) begin : g_bad_n
            $error("tmr_adder_ctrl: N must be at least 2");
        end
        if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
            $error("tmr_adder_ctrl: MAX_RETRY must be in 1..7");
        end
    endgenerate

    // State register. Reset returns to LOAD and drops any pending work.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) so every flop samples pre-edge values, whatever order the blocks run in.
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake outputs and datapath strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_next   = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        load_fire    = 1'b0;
        eval_pass    = 1'b0;
        eval_fail    = 1'b0;
        release_fire = 1'b0;
`ifdef TMR_ADDER_CTRL_RETRY_EN
        retry_fire   = 1'b0;
`endif
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_fire = 1'b1;
                    if (count == LAST_IDX) begin
                        state_next = EVAL;
                    end
                end
            end
            EVAL: begin
                if (!tree_invalid) begin
                    eval_pass  = 1'b1;
                    state_next = DONE;
                end else begin
`ifdef TMR_ADDER_CTRL_RETRY_EN
                    if (retry_left) begin
                        // Hold the operands one more cycle so the tree re-votes.
                        retry_fire = 1'b1;
                    end else begin
                        eval_fail  = 1'b1;
                        state_next = DONE;
                    end
`else
                    eval_fail  = 1'b1;
                    state_next = DONE;
`endif
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    release_fire = 1'b1;
                    state_next   = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Modulo-N transfer counter. It wraps to zero on the N-th transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load_fire) begin
            count <= (count == LAST_IDX) ? '0 : count + CNT_W'(1);
        end
    end

    // Operand bus. Transfer k lands in slot N-1-k, so the first operand is in the MSB slice.
    always_ff @(posedge clk) begin
        // NOTE: this wide register is reset, unlike a RAM, because its cleared value is visible on the port.
        if (rst) begin
            operand <= '0;
        end else if (load_fire) begin
            for (int i = 0; i < N; i++) begin
                if (count == CNT_W'(i)) begin
                    operand[(N - i)*WIDTH-1 -: WIDTH] <= in_data;
                end
            end
        end
    end

    // Result register. It captures the tree sum unchanged, or a zeroed error result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (eval_pass) begin
            out_data <= tree_sum;
            out_err  <= 1'b0;
        end else if (eval_fail) begin
            out_data <= '0;
            out_err  <= 1'b1;
        end
    end

`ifdef TMR_ADDER_CTRL_RETRY_EN
    // Retry counter. It counts re-evaluations and clears once the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (retry_fire) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end else if (release_fire) begin
            retry_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_tmr_adder_ctrl.sv
// tb_tmr_adder_ctrl
// Self-checking bench for tmr_adder_ctrl. The adder tree is a stub driven
// by the bench: it presents a chosen sum and asserts the voter flag for a
// chosen number of evaluation cycles. A transaction-level model predicts the
// operand bus, the result and the output latency. Works with and without
// TMR_ADDER_CTRL_RETRY_EN.
module tb_tmr_adder_ctrl;

    localparam int N         = 8;
    localparam int WIDTH     = 16;
    localparam int MAX_RETRY = 2;
`ifdef TMR_ADDER_CTRL_RETRY_EN
    localparam int EVAL_BUDGET = MAX_RETRY + 1;
`else
    localparam int EVAL_BUDGET = 1;
`endif

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   operand;
    logic [WIDTH-1:0]     tree_sum;
    logic                 tree_invalid;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_err;
    logic                 out_ready;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state.
    logic [N*WIDTH-1:0] exp_operand;
    logic [WIDTH-1:0]   exp_data;
    logic               exp_err;

    logic [WIDTH-1:0] dir_ops [N] = '{16'h007a, 16'h0031, 16'h04d7, 16'h83e1,
                                      16'h81cc, 16'h801b, 16'h0040, 16'h020a};
    logic [N*WIDTH-1:0] dir_bus = 128'h007a_0031_04d7_83e1_81cc_801b_0040_020a;

    tmr_adder_ctrl #(.N(N), .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .operand      (operand),
        .tree_sum     (tree_sum),
        .tree_invalid (tree_invalid),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_err      (out_err),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [N*WIDTH-1:0] got,
                         input logic [N*WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Synchronous reset with a competing handshake on the same edge. It then checks the cleared state.
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        in_valid     = 1'b1;
        in_data      = WIDTH'($urandom);
        out_ready    = 1'b1;
        tree_invalid = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_operand = '0;
        check("rst_operand",   operand,   '0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  '0);
        check("rst_out_err",   out_err,   0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_busy",      busy,      0);
    endtask

    // Feed operands. It returns just after the clock edge of the last transfer.
    task automatic load_ops(input int nops, input bit gapped, input bit directed);
        for (int k = 0; k < nops; k++) begin
            @(negedge clk);
            if (gapped) begin
                in_valid  = 1'b0;
                in_data   = WIDTH'($urandom);
                out_ready = 1'($urandom);
                @(negedge clk);
            end
            check("load_in_ready", in_ready, 1);
            check("load_busy",     busy,     0);
            in_valid    = 1'b1;
            in_data     = directed ? dir_ops[k] : WIDTH'($urandom);
            out_ready   = 1'($urandom);
            exp_operand = (exp_operand << WIDTH) | {{(N-1)*WIDTH{1'b0}}, in_data};
            @(posedge clk);
        end
    endtask

    // Stub the tree through the evaluation phase and check the predicted result.
    task automatic wait_result(input int nfail, input logic [WIDTH-1:0] sum, output bit got);
        int evals;
        int lat;
        int exp_lat;
        evals = 0;
        lat   = 0;
        got   = 1'b0;
        if (nfail < EVAL_BUDGET) begin
            exp_err  = 1'b0;
            exp_data = sum;
            exp_lat  = 2 + nfail;
        end else begin
            exp_err  = 1'b1;
            exp_data = '0;
            exp_lat  = 1 + EVAL_BUDGET;
        end
        tree_sum = sum;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                got = 1'b1;
            end else begin
                check("eval_in_ready", in_ready, 0);
                check("eval_busy",     busy,     1);
                check("eval_operand",  operand,  exp_operand);
                tree_invalid = (evals < nfail);
                in_valid     = 1'b1;
                in_data      = WIDTH'($urandom);
                out_ready    = 1'b0;
                evals++;
            end
        end
        tree_invalid = 1'b0;
        out_ready    = 1'b0;
        if (got) begin
            check("latency",      lat,      exp_lat);
            check("out_data",     out_data, exp_data);
            check("out_err",      out_err,  exp_err);
            check("done_operand", operand,  exp_operand);
            check("done_busy",    busy,     1);
        end else begin
            check("result_timeout", 0, 1);
        end
    endtask

    // Hold the result for a while under input pressure, then accept it.
    task automatic release_result(input int stall);
        for (int i = 0; i < stall; i++) begin
            in_valid  = 1'b1;
            in_data   = WIDTH'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data",  out_data,  exp_data);
            check("stall_out_err",   out_err,   exp_err);
            check("stall_in_ready",  in_ready,  0);
            check("stall_operand",   operand,   exp_operand);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_out_valid", out_valid, 0);
        check("rel_in_ready",  in_ready,  1);
        check("rel_busy",      busy,      0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_txn(input bit gapped, input bit directed, input int nfail,
                           input int stall, input logic [WIDTH-1:0] sum);
        bit got;
        load_ops(N, gapped, directed);
        wait_result(nfail, sum, got);
        if (got) begin
            release_result(stall);
        end else begin
            do_reset();
        end
    endtask

    initial begin
        bit got;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        tree_sum     = '0;
        tree_invalid = 1'b0;
        out_ready    = 1'b0;
        exp_operand  = '0;
        exp_data     = '0;
        exp_err      = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Clean sum with the directed operand set.
        load_ops(N, 1'b0, 1'b1);
        wait_result(0, 16'h01c7, got);
        check("dir_operand_bus", operand, dir_bus);
        if (got) release_result(0);
        else do_reset();

        // Transient fault on the first evaluation.
        run_txn(1'b0, 1'b1, 1, 0, 16'h01c7);

        // Persistent fault.
        run_txn(1'b0, 1'b1, 100, 0, 16'h01c7);

        // Back-pressure in DONE for 5 cycles.
        run_txn(1'b0, 1'b1, 0, 5, 16'h01c7);

        // Reset after 4 operands, then a full new set.
        load_ops(4, 1'b0, 1'b0);
        do_reset();
        run_txn(1'b0, 1'b0, 0, 1, 16'h01c7);

        // Gapped input.
        run_txn(1'b1, 1'b0, 0, 0, 16'h01c7);

        // Reset during EVAL.
        load_ops(N, 1'b0, 1'b0);
        do_reset();

        // Reset during a DONE stall.
        load_ops(N, 1'b0, 1'b0);
        wait_result(0, 16'h5a5a, got);
        do_reset();

        // Randomised transactions.
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 1'b0, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), WIDTH'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
